odelay_step_arbiter: RTL and testbench

Shared sequencer that walks several ODELAYE3 taps from their current readback to their software target in bounded steps. Each step is at most STEP_MAX taps, and only one tap is written per service slot. It sits between the register-mapped per-channel delay targets and the ODELAY primitives in the read/reset/trigger output path. It arbitrates the single write port round-robin across channels, so simultaneous retunes never exceed the primitive's per-update step limit.

---
 rtl/odelay_step_arbiter.sv | 162 ++++++++++++++++
 tb/tb_odelay_step_arbiter.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/odelay_step_arbiter.sv
// odelay_step_arbiter
//
// Shared sequencer that walks several ODELAYE3 taps from their current readback
// to their software target in bounded steps. One tap write per service slot, with
// the single write port granted round-robin across channels.
//
// Parameters:
//   NCH        number of delay channels (1..16)
//   STEP_MAX   maximum tap change per write, 0 = jump straight to target
//   SETTLE_CYC idle cycles after each write before the next arbitration (1..15)
//
// Ports:
//   clk160          system clock
//   rstb            synchronous, active-low reset
//   delay_target    per-channel target tap, channel i in bits [9i+8:9i]
//   delay_out       per-channel CNTVALUEOUT readback, same packing
//   hold            blocks the start of a new slot; a slot in progress completes
//   delay_set_value shared CNTVALUEIN bus, holds the last written value
//   delay_load      one-hot per-channel LOAD strobe, one cycle per slot
//   grant           channel index of the current or most recent slot
//   busy            high whenever a slot is in progress
//   ready           per-channel readback == target (combinational)
//   all_ready       AND of ready
//   err             sticky per-channel verify failure flags
//
// Build option: define ODELAY_ARB_VERIFY_EN to compare the granted channel's
// readback against the written value on the last settle cycle and latch err.
// Without it err is tied to zero.

module odelay_step_arbiter #(
    parameter int unsigned NCH        = 4,
    parameter int unsigned STEP_MAX   = 8,
    parameter int unsigned SETTLE_CYC = 4,
    localparam int unsigned GW        = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clk160,
    input  logic             rstb,
    input  logic [9*NCH-1:0] delay_target,
    input  logic [9*NCH-1:0] delay_out,
    input  logic             hold,
    output logic [8:0]       delay_set_value,
    output logic [NCH-1:0]   delay_load,
    output logic [GW-1:0]    grant,
    output logic             busy,
    output logic [NCH-1:0]   ready,
    output logic             all_ready,
    output logic [NCH-1:0]   err
);

    localparam logic [GW-1:0] LAST_CH     = GW'(NCH - 1);
    localparam logic [3:0]    SETTLE_LAST = 4'(SETTLE_CYC - 1);
    localparam logic [9:0]    STEP10      = (STEP_MAX > 511) ? 10'd511 : 10'(STEP_MAX);

    typedef enum logic [2:0] {StArb, StSample, StCalc, StWrite, StSettle} state_e;

    state_e          state_q;
    logic [GW-1:0]   rr_ptr_q;
    logic [8:0]      rd_q;
    logic [8:0]      tg_q;
    logic [3:0]      settle_cnt_q;

    logic            pick_found;
    logic [GW-1:0]   pick_idx;
    logic signed [9:0] diff;
    logic [9:0]      mag;
    logic [9:0]      step;
    logic [8:0]      nxt;

    for (genvar i = 0; i < NCH; i++) begin : g_ready
        assign ready[i] = (delay_out[9*i +: 9] == delay_target[9*i +: 9]);
    end

    assign all_ready = &ready;
    assign busy      = (state_q != StArb);

    // First pending channel at or above rr_ptr, wrapping.
    always_comb begin
        int unsigned idx;
        idx        = 0;
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int unsigned k = 0; k < NCH; k++) begin
            idx = (int'(rr_ptr_q) + k) % NCH;
            if (!pick_found && !ready[idx]) begin
                pick_found = 1'b1;
                pick_idx   = GW'(idx);
            end
        end
    end

    // Clamp the move to +/-STEP_MAX; the result is always back inside 0..511.
    always_comb begin
        diff = $signed({1'b0, tg_q}) - $signed({1'b0, rd_q});
        mag  = diff[9] ? (~diff + 10'd1) : diff;
        step = diff;
        if (STEP_MAX != 0 && {22'd0, mag} > STEP_MAX) begin
            step = diff[9] ? (~STEP10 + 10'd1) : STEP10;
        end
        nxt = rd_q + step[8:0];
    end

    always_ff @(posedge clk160) begin
        if (!rstb) begin
            state_q         <= StArb;
            rr_ptr_q        <= '0;
            grant           <= '0;
            rd_q            <= '0;
            tg_q            <= '0;
            settle_cnt_q    <= '0;
            delay_set_value <= '0;
            delay_load      <= '0;
`ifdef ODELAY_ARB_VERIFY_EN
            err             <= '0;
`endif
        end else begin
            case (state_q)
                StArb: begin
                    if (!hold && pick_found) begin
                        grant   <= pick_idx;
                        state_q <= StSample;
                    end
                end
                StSample: begin
                    rd_q    <= delay_out[9*int'(grant) +: 9];
                    tg_q    <= delay_target[9*int'(grant) +: 9];
                    state_q <= StCalc;
                end
                StCalc: begin
                    // Value and strobe become visible together in the WRITE cycle.
                    delay_set_value <= nxt;
                    delay_load      <= NCH'(1) << grant;
                    state_q         <= StWrite;
                end
                StWrite: begin
                    delay_load   <= '0;
                    rr_ptr_q     <= (grant == LAST_CH) ? '0 : grant + 1'b1;
                    settle_cnt_q <= '0;
                    state_q      <= StSettle;
                end
                StSettle: begin
                    if (settle_cnt_q == SETTLE_LAST) begin
`ifdef ODELAY_ARB_VERIFY_EN
                        // delay_set_value still holds this slot's written tap.
                        if (delay_out[9*int'(grant) +: 9] != delay_set_value) begin
                            err[grant] <= 1'b1;
                        end
`endif
                        state_q <= StArb;
                    end else begin
                        settle_cnt_q <= settle_cnt_q + 4'd1;
                    end
                end
                default: state_q <= StArb;
            endcase
        end
    end

`ifndef ODELAY_ARB_VERIFY_EN
    assign err = '0;
`endif

endmodule

// File: tb/tb_odelay_step_arbiter.sv
// Bench for odelay_step_arbiter: directed scenarios plus randomized retuning,
// checked every cycle against a slot-timeline model of the arbiter.
module tb_odelay_step_arbiter;

    localparam int NCH = 4;
    localparam int SM  = 8;
    localparam int SC  = 4;

    logic             clk160 = 1'b0;
    logic             rstb   = 1'b0;
    logic             hold   = 1'b0;
    logic [9*NCH-1:0] delay_target;
    logic [9*NCH-1:0] delay_out;
    logic [8:0]       delay_set_value;
    logic [NCH-1:0]   delay_load;
    logic [1:0]       grant;
    logic             busy;
    logic [NCH-1:0]   ready;
    logic             all_ready;
    logic [NCH-1:0]   err;

    int tgt[NCH];
    int ro[NCH];
    int init_ro[NCH];
    bit stuck[NCH];

    // Second instance with unlimited step size.
    logic [9*NCH-1:0] z_target;
    logic [9*NCH-1:0] z_out;
    logic [8:0]       z_set;
    logic [NCH-1:0]   z_load;
    logic [1:0]       z_grant;
    logic             z_busy;
    logic [NCH-1:0]   z_ready;
    logic             z_all_ready;
    logic [NCH-1:0]   z_err;
    int               z_tgt[NCH];
    int               z_ro[NCH];
    int               z_loads;
    int               z_last;
    logic [NCH-1:0]   z_lastld;

    int tests = 0;
    int fails = 0;

    // Model state: slot timeline measured in clock edges since the grant edge.
    int cyc = 0;
    int m_active = 0;
    int m_start = 0;
    int m_grant = 0;
    int m_ptr = 0;
    int m_rd = 0;
    int m_tg = 0;
    int m_set = 0;
    int m_e = 0;
    int m_found = 0;
    int m_idx = 0;
    bit [NCH-1:0] m_err = '0;

    int lv[$];
    int lc[$];
    int lt[$];

    always #5 clk160 = ~clk160;

    always_comb begin
        delay_target = '0;
        delay_out    = '0;
        z_target     = '0;
        z_out        = '0;
        for (int i = 0; i < NCH; i++) begin
            delay_target[9*i +: 9] = 9'(tgt[i]);
            delay_out[9*i +: 9]    = 9'(ro[i]);
            z_target[9*i +: 9]     = 9'(z_tgt[i]);
            z_out[9*i +: 9]        = 9'(z_ro[i]);
        end
    end

    odelay_step_arbiter #(.NCH(NCH), .STEP_MAX(SM), .SETTLE_CYC(SC)) u_dut (
        .clk160(clk160), .rstb(rstb), .delay_target(delay_target), .delay_out(delay_out),
        .hold(hold), .delay_set_value(delay_set_value), .delay_load(delay_load),
        .grant(grant), .busy(busy), .ready(ready), .all_ready(all_ready), .err(err)
    );

    odelay_step_arbiter #(.NCH(NCH), .STEP_MAX(0), .SETTLE_CYC(SC)) u_dut_nolimit (
        .clk160(clk160), .rstb(rstb), .delay_target(z_target), .delay_out(z_out),
        .hold(1'b0), .delay_set_value(z_set), .delay_load(z_load),
        .grant(z_grant), .busy(z_busy), .ready(z_ready), .all_ready(z_all_ready), .err(z_err)
    );

    // ODELAY primitives: readback follows LOAD unless the channel is stuck.
    always @(posedge clk160) begin
        for (int i = 0; i < NCH; i++) begin
            if (!rstb) ro[i] <= init_ro[i];
            else if (delay_load[i] && !stuck[i]) ro[i] <= int'(delay_set_value);
            if (!rstb) z_ro[i] <= 0;
            else if (z_load[i]) z_ro[i] <= int'(z_set);
        end
        if (!rstb) begin
            z_loads <= 0;
        end else if (|z_load) begin
            z_loads  <= z_loads + 1;
            z_last   <= int'(z_set);
            z_lastld <= z_load;
        end
    end

    function automatic int step_to(int rd, int tg);
        int d;
        d = tg - rd;
        if (SM != 0 && (d > SM || d < -SM)) d = (d > 0) ? SM : -SM;
        return rd + d;
    endfunction

    // Reference model, evaluated on pre-edge input values.
    always @(posedge clk160) begin
        cyc = cyc + 1;
        if (!rstb) begin
            m_active = 0; m_set = 0; m_grant = 0; m_ptr = 0; m_err = '0;
        end else if (m_active == 0) begin
            m_found = 0;
            if (!hold) begin
                for (int k = 0; k < NCH; k++) begin
                    m_idx = (m_ptr + k) % NCH;
                    if (m_found == 0 && ro[m_idx] != tgt[m_idx]) begin
                        m_found = 1; m_grant = m_idx;
                    end
                end
            end
            if (m_found != 0) begin
                m_active = 1; m_start = cyc;
            end
        end else begin
            m_e = cyc - m_start;
            if (m_e == 1) begin
                m_rd = ro[m_grant]; m_tg = tgt[m_grant];
            end else if (m_e == 2) begin
                m_set = step_to(m_rd, m_tg);
            end else if (m_e == 3) begin
                m_ptr = (m_grant + 1) % NCH;
            end else if (m_e == 3 + SC) begin
`ifdef ODELAY_ARB_VERIFY_EN
                if (ro[m_grant] != m_set) m_err[m_grant] = 1'b1;
`endif
                m_active = 0;
            end
        end
    end

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic compare_all();
        logic [NCH-1:0] exp_load;
        logic [NCH-1:0] exp_ready;
        exp_load  = '0;
        exp_ready = '0;
        if (m_active != 0 && cyc - m_start == 2) exp_load[m_grant] = 1'b1;
        for (int i = 0; i < NCH; i++) exp_ready[i] = (ro[i] == tgt[i]);
        check("delay_set_value", 32'(delay_set_value), 32'(m_set));
        check("delay_load", 32'(delay_load), 32'(exp_load));
        check("grant", 32'(grant), 32'(m_grant));
        check("busy", 32'(busy), 32'(m_active != 0));
        check("ready", 32'(ready), 32'(exp_ready));
        check("all_ready", 32'(all_ready), 32'(&exp_ready));
        check("err", 32'(err), 32'(m_err));
        if (|delay_load) begin
            for (int i = 0; i < NCH; i++) if (delay_load[i]) lc.push_back(i);
            lv.push_back(int'(delay_set_value));
            lt.push_back(cyc);
        end
    endtask

    // One cycle: compare mid-cycle, then return just after the next rising edge.
    task automatic tick();
        @(negedge clk160);
        compare_all();
        @(posedge clk160);
        #2;
    endtask

    task automatic wait_idle(int bound);
        int k;
        k = 0;
        repeat (2) tick();
        while (!(all_ready && !busy) && k < bound) begin
            tick();
            k++;
        end
        check("idle_reached", 32'(all_ready && !busy), 32'd1);
    endtask

    task automatic do_reset();
        for (int i = 0; i < NCH; i++) init_ro[i] = tgt[i];
        rstb = 1'b0;
        repeat (2) tick();
        rstb = 1'b1;
    endtask

    initial begin
        int base;
        int k;
        int rel_cyc;
        for (int i = 0; i < NCH; i++) begin
            tgt[i] = 0; init_ro[i] = 0; stuck[i] = 1'b0; z_tgt[i] = 0;
        end
        @(posedge clk160);
        #2;
        tick();
        check("rst_set_value", 32'(delay_set_value), 32'd0);
        check("rst_load", 32'(delay_load), 32'd0);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        rstb = 1'b1;

        // Ch0 0 -> 20 in steps of 8; unlimited-step instance jumps ch3 0 -> 300.
        base = lv.size();
        tgt[0] = 20;
        z_tgt[3] = 300;
        wait_idle(200);
        check("a_nwrites", 32'(lv.size() - base), 32'd3);
        if (lv.size() >= base + 3) begin
            check("a_w0", 32'(lv[base]), 32'd8);
            check("a_w1", 32'(lv[base+1]), 32'd16);
            check("a_w2", 32'(lv[base+2]), 32'd20);
            check("a_ch", 32'(lc[base] + lc[base+1] + lc[base+2]), 32'd0);
            check("a_gap0", 32'(lt[base+1] - lt[base]), 32'd8);
            check("a_gap1", 32'(lt[base+2] - lt[base+1]), 32'd8);
        end
        check("a_ready0", 32'(ready[0]), 32'd1);
        check("a_busy", 32'(busy), 32'd0);
        check("z_nloads", 32'(z_loads), 32'd1);
        check("z_value", 32'(z_last), 32'd300);
        check("z_strobe", 32'(z_lastld), 32'b1000);
        check("z_ready", 32'(z_ready), 32'hf);
        check("z_idle", 32'(z_busy | z_all_ready << 1), 32'd2);
        check("z_grant", 32'(z_grant), 32'd3);
        check("z_err", 32'(z_err), 32'd0);

        // Ch1 100 -> 85.
        tgt[1] = 100;
        do_reset();
        base = lv.size();
        tgt[1] = 85;
        wait_idle(200);
        check("b_nwrites", 32'(lv.size() - base), 32'd2);
        if (lv.size() >= base + 2) begin
            check("b_w0", 32'(lv[base]), 32'd92);
            check("b_w1", 32'(lv[base+1]), 32'd85);
            check("b_ch", 32'(lc[base] * 4 + lc[base+1]), 32'd5);
        end

        // Ch0 and ch2 0 -> 16 together, pointer at 0 after reset.
        tgt[0] = 0;
        tgt[2] = 0;
        do_reset();
        base = lv.size();
        tgt[0] = 16;
        tgt[2] = 16;
        wait_idle(200);
        check("c_nwrites", 32'(lv.size() - base), 32'd4);
        if (lv.size() >= base + 4) begin
            check("c_order", 32'(lc[base]*64 + lc[base+1]*16 + lc[base+2]*4 + lc[base+3]),
                  32'(0*64 + 2*16 + 0*4 + 2));
            check("c_vals", 32'(lv[base]*1000 + lv[base+1]*100 + lv[base+2]*10 + lv[base+3]),
                  32'(8*1000 + 8*100 + 16*10 + 16));
        end

        // Hold blocks new slots; release gives ARB -> WRITE in 3 cycles.
        hold = 1'b1;
        tgt[0] = 40;
        base = lv.size();
        repeat (50) tick();
        check("hold_no_load", 32'(lv.size() - base), 32'd0);
        hold = 1'b0;
        rel_cyc = cyc;
        k = 0;
        while (lv.size() == base && k < 20) begin
            tick();
            k++;
        end
        check("hold_release_seen", 32'(lv.size() > base), 32'd1);
        if (lv.size() > base) check("arb_to_write", 32'(lt[base] - rel_cyc), 32'd3);
        wait_idle(200);

        // Reset in the middle of SETTLE.
        tgt[3] = 50;
        base = lv.size();
        k = 0;
        while (lv.size() == base && k < 20) begin
            tick();
            k++;
        end
        repeat (2) tick();
        check("pre_rst_busy", 32'(busy), 32'd1);
        rstb = 1'b0;
        tick();
        check("mid_rst_set_value", 32'(delay_set_value), 32'd0);
        check("mid_rst_load", 32'(delay_load), 32'd0);
        check("mid_rst_grant", 32'(grant), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_err", 32'(err), 32'd0);
        rstb = 1'b1;
        wait_idle(300);

        // Randomized retuning with random hold.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 19) == 0) tgt[$urandom_range(0, NCH-1)] = int'($urandom_range(0, 511));
            if ($urandom_range(0, 15) == 0) hold = ~hold;
            tick();
        end
        hold = 1'b0;
        wait_idle(3000);

        // Ch2 readback stuck at 0 with target 10.
        tgt[2] = 0;
        do_reset();
        stuck[2] = 1'b1;
        tgt[2] = 10;
        base = lv.size();
        k = 0;
        while (lv.size() == base && k < 30) begin
            tick();
            k++;
        end
        repeat (SC + 1) tick();
`ifdef ODELAY_ARB_VERIFY_EN
        check("verify_err", 32'(err), 32'b0100);
`else
        check("verify_err", 32'(err), 32'd0);
`endif
        repeat (20) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
